// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU operation codes and the
// writeback / immediate-format encodings used by the control decoder.
package rv32i_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLT  = 4'b0101,
        ALU_SLTU = 4'b0110,
        ALU_SLL  = 4'b0111,
        ALU_SRL  = 4'b1000,
        ALU_SRA  = 4'b1001
    } alu_ctrl_e;

    // How the ALU decoder should treat funct3/f7b5 for the current opcode.
    typedef enum logic [1:0] {
        CLS_ADD    = 2'b00,
        CLS_SUB    = 2'b01,
        CLS_OP     = 2'b10,
        CLS_OP_IMM = 2'b11
    } alu_class_e;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/rv32i_decoder_alu_decoder.sv
// ALU operation decoder: maps the opcode class, funct3 and instruction bit 30
// onto the ALU control code.
import rv32i_pkg::*;

module alu_decoder (
    input  alu_class_e i_alu_class,
    input  logic [2:0] i_funct3,
    input  logic       i_f7b5,
    output alu_ctrl_e  o_alu_control
);

    always_comb begin
        o_alu_control = ALU_ADD;
        case (i_alu_class)
            CLS_ADD: o_alu_control = ALU_ADD;
            CLS_SUB: o_alu_control = ALU_SUB;
            CLS_OP, CLS_OP_IMM: begin
                case (i_funct3)
                    // Immediate forms have no subtract; bit 30 is part of the immediate there.
                    F3_ADD:  o_alu_control = (i_alu_class == CLS_OP && i_f7b5) ? ALU_SUB : ALU_ADD;
                    F3_SLL:  o_alu_control = ALU_SLL;
                    F3_SLT:  o_alu_control = ALU_SLT;
                    F3_SLTU: o_alu_control = ALU_SLTU;
                    F3_XOR:  o_alu_control = ALU_XOR;
                    F3_SR:   o_alu_control = i_f7b5 ? ALU_SRA : ALU_SRL;
                    F3_OR:   o_alu_control = ALU_OR;
                    F3_AND:  o_alu_control = ALU_AND;
                    default: o_alu_control = ALU_ADD;
                endcase
            end
            default: o_alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/rv32i_decoder.sv
// RV32I single-cycle control decoder. Defining DECODER_ILLEGAL_EN adds the
// sticky illegal_instr output and its flop; decode is identical either way.
import rv32i_pkg::*;

module rv32i_decoder (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic        equal,
    input  logic        less_than,
    input  logic        less_than_unsigned,
    output logic        pc_src,
    output logic [1:0]  result_src,
    output logic        mem_write,
    output logic [3:0]  alu_control,
    output logic        alu_src,
    output logic [1:0]  immediate_control,
    output logic        reg_write
`ifdef DECODER_ILLEGAL_EN
    ,
    output logic        illegal_instr
`endif
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic       w_f7b5;
    logic       w_branch_taken;
    logic       w_branch_f3_ok;
    logic       w_illegal;
    alu_class_e w_alu_class;
    alu_ctrl_e  w_alu_ctrl;

    assign w_opcode = instruction[6:0];
    assign w_funct3 = instruction[14:12];
    assign w_f7b5   = instruction[30];

    // Register specifiers and immediates are consumed by the datapath, not here.
    logic w_unused_fields;
    assign w_unused_fields = ^{instruction[31], instruction[29:15], instruction[11:7]};

    always_comb begin
        w_branch_f3_ok = 1'b1;
        w_branch_taken = 1'b0;
        case (w_funct3)
            F3_BEQ:  w_branch_taken = equal;
            F3_BNE:  w_branch_taken = ~equal;
            F3_BLT:  w_branch_taken = less_than;
            F3_BGE:  w_branch_taken = ~less_than;
            F3_BLTU: w_branch_taken = less_than_unsigned;
            F3_BGEU: w_branch_taken = ~less_than_unsigned;
            default: w_branch_f3_ok = 1'b0;
        endcase
    end

    // Every control defaults to 0 so an illegal instruction writes no state.
    always_comb begin
        pc_src            = 1'b0;
        result_src        = RES_ALU;
        mem_write         = 1'b0;
        alu_src           = 1'b0;
        immediate_control = IMM_I;
        reg_write         = 1'b0;
        w_alu_class       = CLS_ADD;
        w_illegal         = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                reg_write   = 1'b1;
                w_alu_class = CLS_OP;
            end
            OPC_OP_IMM: begin
                reg_write   = 1'b1;
                alu_src     = 1'b1;
                w_alu_class = CLS_OP_IMM;
            end
            OPC_LOAD: begin
                reg_write  = 1'b1;
                alu_src    = 1'b1;
                result_src = RES_MEM;
            end
            OPC_STORE: begin
                mem_write         = 1'b1;
                alu_src           = 1'b1;
                immediate_control = IMM_S;
            end
            OPC_BRANCH: begin
                if (w_branch_f3_ok) begin
                    pc_src            = w_branch_taken;
                    immediate_control = IMM_B;
                    w_alu_class       = CLS_SUB;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            OPC_JAL: begin
                pc_src            = 1'b1;
                immediate_control = IMM_J;
                result_src        = RES_PC4;
                reg_write         = 1'b1;
            end
            OPC_JALR: begin
                pc_src     = 1'b1;
                alu_src    = 1'b1;
                result_src = RES_PC4;
                reg_write  = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    alu_decoder u_alu_decoder (
        .i_alu_class   (w_alu_class),
        .i_funct3      (w_funct3),
        .i_f7b5        (w_f7b5),
        .o_alu_control (w_alu_ctrl)
    );

    assign alu_control = w_alu_ctrl;

`ifdef DECODER_ILLEGAL_EN
    logic r_illegal;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_illegal <= 1'b0;
        end else if (w_illegal) begin
            r_illegal <= 1'b1;
        end
    end

    assign illegal_instr = r_illegal;
`else
    logic w_unused_illegal;
    assign w_unused_illegal = ^{clk, reset, w_illegal};
`endif

endmodule

// File: tb/tb_rv32i_decoder.sv
// Bench for rv32i_decoder: directed decode vectors followed by randomized
// instructions checked against a reference model built from the ISA rules.
module tb_rv32i_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic        equal;
    logic        less_than;
    logic        less_than_unsigned;
    logic        pc_src;
    logic [1:0]  result_src;
    logic        mem_write;
    logic [3:0]  alu_control;
    logic        alu_src;
    logic [1:0]  immediate_control;
    logic        reg_write;
`ifdef DECODER_ILLEGAL_EN
    logic        illegal_instr;
`endif

    int          n_vec = 0;
    int          n_err = 0;
    logic [11:0] exp_q[$];
    logic        exp_flag = 1'b0;

    rv32i_decoder dut (
        .clk                (clk),
        .reset              (reset),
        .instruction        (instruction),
        .equal              (equal),
        .less_than          (less_than),
        .less_than_unsigned (less_than_unsigned),
        .pc_src             (pc_src),
        .result_src         (result_src),
        .mem_write          (mem_write),
        .alu_control        (alu_control),
        .alu_src            (alu_src),
        .immediate_control  (immediate_control),
        .reg_write          (reg_write)
`ifdef DECODER_ILLEGAL_EN
        ,
        .illegal_instr      (illegal_instr)
`endif
    );

    always #5 clk = ~clk;

    // Reference: {illegal, pc_src, result_src, mem_write, alu_control, alu_src, imm, reg_write}.
    // Branch outcome is computed from the compared operand values themselves.
    function automatic logic [12:0] ref_decode(input logic [31:0] ins, input logic [31:0] a,
                                               input logic [31:0] b);
        int          alu_of_f3 [8] = '{0, 7, 5, 6, 4, 8, 3, 2};
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7b5;
        logic        pc, mw, asrc, rw, bad, take;
        logic [1:0]  res, imm;
        int          alu;
        op   = ins[6:0];
        f3   = ins[14:12];
        f7b5 = ins[30];
        pc = 0; mw = 0; asrc = 0; rw = 0; bad = 0; take = 0;
        res = 0; imm = 0; alu = 0;
        case (op)
            7'h33: begin
                alu = alu_of_f3[f3] + (((f3 == 0 || f3 == 5) && f7b5) ? 1 : 0);
                rw  = 1;
            end
            7'h13: begin
                alu  = alu_of_f3[f3] + ((f3 == 5 && f7b5) ? 1 : 0);
                asrc = 1;
                rw   = 1;
            end
            7'h03: begin asrc = 1; res = 1; rw = 1; end
            7'h23: begin asrc = 1; imm = 1; mw = 1; end
            7'h63: begin
                case (f3[2:1])
                    2'b00: take = (a == b);
                    2'b10: take = ($signed(a) < $signed(b));
                    2'b11: take = (a < b);
                    default: bad = 1;
                endcase
                pc  = take ^ f3[0];
                alu = 1;
                imm = 2;
            end
            7'h6F: begin pc = 1; imm = 3; res = 2; rw = 1; end
            7'h67: begin pc = 1; asrc = 1; res = 2; rw = 1; end
            default: bad = 1;
        endcase
        if (bad) return 13'h1000;
        return {1'b0, pc, res, mw, 4'(alu), asrc, imm, rw};
    endfunction

    task automatic step(input string tag, input logic [31:0] ins, input logic [31:0] a,
                        input logic [31:0] b);
        logic [12:0] e;
        logic [11:0] got;
        logic [11:0] want;
        @(negedge clk);
        instruction        = ins;
        equal              = (a == b);
        less_than          = ($signed(a) < $signed(b));
        less_than_unsigned = (a < b);
        e = ref_decode(ins, a, b);
        exp_q.push_back(e[11:0]);
        #2;
        got  = {pc_src, result_src, mem_write, alu_control, alu_src, immediate_control, reg_write};
        want = exp_q.pop_front();
        n_vec++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s instr=%h observed=%h expected=%h", tag, ins, got, want);
        end
`ifdef DECODER_ILLEGAL_EN
        @(posedge clk);
        #1;
        exp_flag = reset ? 1'b0 : (exp_flag | e[12]);
        n_vec++;
        assert (illegal_instr === exp_flag) else begin
            n_err++;
            $error("FAIL %s_flag instr=%h observed=%b expected=%b", tag, ins, illegal_instr, exp_flag);
        end
`endif
    endtask

    initial begin
        logic [6:0]  op_tab [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h00};
        logic [31:0] rnd;
        logic [31:0] a;
        logic [31:0] b;
        logic [6:0]  op;
        reset              = 1'b1;
        instruction        = 32'h0000_0000;
        equal              = 1'b0;
        less_than          = 1'b0;
        less_than_unsigned = 1'b0;
        repeat (2) @(posedge clk);
        #1;
`ifdef DECODER_ILLEGAL_EN
        n_vec++;
        assert (illegal_instr === 1'b0) else begin
            n_err++;
            $error("FAIL reset_flag observed=%b expected=0", illegal_instr);
        end
`endif
        // Decode must ignore reset.
        step("add_in_reset", 32'h002081B3, 32'd1, 32'd2);
        reset = 1'b0;

        step("add",       32'h002081B3, 32'd1, 32'd2);
        step("sub",       32'h402081B3, 32'd1, 32'd2);
        step("srai",      32'h4020D193, 32'd1, 32'd2);
        step("lw",        32'h00812283, 32'd1, 32'd2);
        step("sw",        32'h00512423, 32'd1, 32'd2);
        step("beq_taken", 32'h00208463, 32'd5, 32'd5);
        step("beq_not",   32'h00208463, 32'd5, 32'd6);
        step("bge_taken", 32'h00E0D463, 32'd5, 32'd3);
        step("bltu_neg",  32'h0020E463, 32'd5, 32'hFFFF_FFF0);
        step("jal",       32'h010000EF, 32'd0, 32'd0);
        step("jalr",      32'h000080E7, 32'd0, 32'd0);
        step("opc_7f",    32'h0000007F, 32'd0, 32'd0);
        step("hold_add",  32'h002081B3, 32'd1, 32'd2);
        step("br_f3_010", 32'h0020A063, 32'd1, 32'd1);
        step("lui",       32'h000000B7, 32'd0, 32'd0);
        reset = 1'b1;
        step("rst_prio",  32'h0000007F, 32'd0, 32'd0);
        reset = 1'b0;
        step("after_rst", 32'h00512423, 32'd1, 32'd2);

        for (int i = 0; i < 400; i++) begin
            rnd = $urandom();
            op  = op_tab[$urandom_range(0, 8)];
            if (op == 7'h00) begin
                op = rnd[6:0];
            end
            a = $urandom();
            b = $urandom();
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = {~a[31], a[30:0]};
                default: ;
            endcase
            reset = ((i % 97) == 50);
            step("random", {rnd[31:7], op}, a, b);
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
